memory_access: RTL and testbench

Pipeline MEM stage sitting directly downstream of the execute stage in the 64-bit LEGv8 pipeline.
- Registers execute outputs into the EX/MEM register.
- Resolves the branch (PCSrc_M).
- Performs data-memory read/write over a ready-based handshake with wait-state and timeout handling.
- Feeds the MEM/WB register for writeback, stalling the upstream pipeline while an access is outstanding.

---
 rtl/pipeline_pkg.sv | 40 ++++
 rtl/flopenrc.sv | 18 +
 rtl/memory_access.sv | 157 +++++++++++++++
 tb/tb_memory_access.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared types for the LEGv8 MEM stage: FSM states, fault codes and the
// EX/MEM and MEM/WB pipeline-register layouts.
package pipeline_pkg;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FAULT = 2'd2
  } mem_state_t;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

  typedef struct packed {
    logic            valid;
    logic            branch;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic            mem_to_reg;
    logic            zero;
    logic [4:0]      write_reg;
    logic [XLEN-1:0] pc_branch;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] write_data;
  } exmem_t;

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic            mem_to_reg;
    logic [4:0]      write_reg;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] read_data;
  } memwb_t;

endpackage

// File: rtl/flopenrc.sv
// Pipeline register with synchronous reset, load enable and clear-to-bubble.
module flopenrc #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)     q <= '0;
    else if (en)   q <= clear ? '0 : d;
  end

endmodule

// File: rtl/memory_access.sv
// LEGv8 MEM stage: EX/MEM register, branch resolve, ready-handshaked data
// memory access with timeout/misalign faults, and the MEM/WB register.
module memory_access
  import pipeline_pkg::*;
#(
  parameter int N       = 64,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_E,
  input  logic [N-1:0] PCBranch_E,
  input  logic [N-1:0] aluResult_E,
  input  logic [N-1:0] writeData_E,
  input  logic         zero_E,
  input  logic [4:0]   writeReg_E,
  input  logic         Branch_E,
  input  logic         MemRead_E,
  input  logic         MemWrite_E,
  input  logic         RegWrite_E,
  input  logic         MemtoReg_E,
  output logic         dm_req,
  output logic         dm_we,
  output logic [N-1:0] dm_addr,
  output logic [N-1:0] dm_wdata,
  input  logic         dm_ready,
  input  logic [N-1:0] dm_rdata,
  output logic         stall_M,
  output logic         PCSrc_M,
  output logic [N-1:0] PCBranch_M,
  output logic         valid_W,
  output logic         RegWrite_W,
  output logic         MemtoReg_W,
  output logic [4:0]   writeReg_W,
  output logic [N-1:0] aluResult_W,
  output logic [N-1:0] readData_W,
  output logic         fault,
  output logic [1:0]   fault_code
);

  localparam int CW = $clog2(TIMEOUT + 1);

  if (N != XLEN) begin : g_width_check
    $error("memory_access: N must equal pipeline_pkg::XLEN");
  end

  exmem_t     ex_d, ex_q;
  memwb_t     wb_d, wb_q;
  mem_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0] fcode_n;
  logic       mem_op, aligned;

  always_comb begin
    ex_d            = '0;
    ex_d.valid      = valid_E;
    ex_d.branch     = Branch_E;
    ex_d.mem_read   = MemRead_E;
    ex_d.mem_write  = MemWrite_E;
    ex_d.reg_write  = RegWrite_E;
    ex_d.mem_to_reg = MemtoReg_E;
    ex_d.zero       = zero_E;
    ex_d.write_reg  = writeReg_E;
    ex_d.pc_branch  = PCBranch_E;
    ex_d.alu_result = aluResult_E;
    ex_d.write_data = writeData_E;
  end

  flopenrc #(.W($bits(exmem_t))) u_exmem (
    .clk(clk), .reset(reset), .en(~stall_M), .clear(1'b0), .d(ex_d), .q(ex_q)
  );

  assign mem_op     = ex_q.valid & (ex_q.mem_read | ex_q.mem_write);
  assign aligned    = (ex_q.alu_result[2:0] == 3'b000);
  assign dm_addr    = ex_q.alu_result;
  assign dm_wdata   = ex_q.write_data;
  assign dm_we      = ex_q.mem_write;
  assign PCSrc_M    = ex_q.valid & ex_q.branch & ex_q.zero;
  assign PCBranch_M = ex_q.pc_branch;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    fcode_n = fault_code;
    dm_req  = 1'b0;
    stall_M = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem_op && !aligned) begin
          // hold the offending instruction in EX/MEM while faulting
          stall_M = 1'b1;
          state_n = FAULT;
          fcode_n = FAULT_MISALIGN;
        end else if (mem_op) begin
          dm_req = 1'b1;
          if (!dm_ready) begin
            stall_M = 1'b1;
            state_n = WAIT;
            cnt_n   = CW'(1);
          end
        end
      end
      WAIT: begin
        dm_req  = 1'b1;
        stall_M = ~dm_ready;
        if (dm_ready) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == CW'(TIMEOUT)) begin
          state_n = FAULT;
          fcode_n = FAULT_TIMEOUT;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      FAULT: stall_M = 1'b1;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      fault_code <= FAULT_NONE;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      fault_code <= fcode_n;
    end
  end

  assign fault = (state == FAULT);

  always_comb begin
    wb_d            = '0;
    wb_d.valid      = ex_q.valid;
    wb_d.reg_write  = ex_q.reg_write;
    wb_d.mem_to_reg = ex_q.mem_to_reg;
    wb_d.write_reg  = ex_q.write_reg;
    wb_d.alu_result = ex_q.alu_result;
    wb_d.read_data  = ex_q.mem_read ? dm_rdata : '0;
  end

  // A stalled cycle sends a bubble down to writeback.
  flopenrc #(.W($bits(memwb_t))) u_memwb (
    .clk(clk), .reset(reset), .en(1'b1), .clear(stall_M), .d(wb_d), .q(wb_q)
  );

  assign valid_W     = wb_q.valid;
  assign RegWrite_W  = wb_q.reg_write;
  assign MemtoReg_W  = wb_q.mem_to_reg;
  assign writeReg_W  = wb_q.write_reg;
  assign aluResult_W = wb_q.alu_result;
  assign readData_W  = wb_q.read_data;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for the MEM stage: zero-wait load, wait-stated store,
// branch resolve, misalign/timeout faults and reset during an access.
module tb_memory_access;

  localparam int N = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid_E, zero_E, Branch_E, MemRead_E, MemWrite_E, RegWrite_E, MemtoReg_E;
  logic [N-1:0] PCBranch_E, aluResult_E, writeData_E;
  logic [4:0]   writeReg_E;
  logic         dm_req, dm_we, dm_ready;
  logic [N-1:0] dm_addr, dm_wdata, dm_rdata;
  logic         stall_M, PCSrc_M;
  logic [N-1:0] PCBranch_M;
  logic         valid_W, RegWrite_W, MemtoReg_W;
  logic [4:0]   writeReg_W;
  logic [N-1:0] aluResult_W, readData_W;
  logic         fault;
  logic [1:0]   fault_code;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  memory_access #(.N(N), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .valid_E(valid_E), .PCBranch_E(PCBranch_E),
    .aluResult_E(aluResult_E), .writeData_E(writeData_E), .zero_E(zero_E),
    .writeReg_E(writeReg_E), .Branch_E(Branch_E), .MemRead_E(MemRead_E),
    .MemWrite_E(MemWrite_E), .RegWrite_E(RegWrite_E), .MemtoReg_E(MemtoReg_E),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_rdata(dm_rdata), .stall_M(stall_M), .PCSrc_M(PCSrc_M),
    .PCBranch_M(PCBranch_M), .valid_W(valid_W), .RegWrite_W(RegWrite_W),
    .MemtoReg_W(MemtoReg_W), .writeReg_W(writeReg_W), .aluResult_W(aluResult_W),
    .readData_W(readData_W), .fault(fault), .fault_code(fault_code)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_e();
    valid_E = 0; zero_E = 0; Branch_E = 0; MemRead_E = 0; MemWrite_E = 0;
    RegWrite_E = 0; MemtoReg_E = 0; PCBranch_E = '0; aluResult_E = '0;
    writeData_E = '0; writeReg_E = '0;
  endtask

  task automatic do_reset();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    clear_e();
    dm_ready = 0; dm_rdata = '0;
    do_reset();
    n_checks++;
    if ({dm_req, stall_M, PCSrc_M, valid_W, RegWrite_W, MemtoReg_W, fault} !== 7'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 0", {dm_req, stall_M, PCSrc_M, valid_W, RegWrite_W, MemtoReg_W, fault});
    end
    n_checks++;
    if ({fault_code, writeReg_W, aluResult_W, readData_W, PCBranch_M} !== '0) begin
      n_fail++; $display("FAIL reset_data: code=%0h wr=%0h alu=%0h rd=%0h pcb=%0h want 0", fault_code, writeReg_W, aluResult_W, readData_W, PCBranch_M);
    end
  endtask

  task automatic test_load_zero_wait();
    valid_E = 1; MemRead_E = 1; RegWrite_E = 1; MemtoReg_E = 1;
    aluResult_E = 64'h40; writeReg_E = 5'd5;
    dm_ready = 1; dm_rdata = 64'hDEAD;
    tick();
    clear_e();
    #1;
    n_checks++;
    if (dm_req !== 1'b1 || stall_M !== 1'b0) begin
      n_fail++; $display("FAIL load_req: dm_req=%b stall=%b want 1/0", dm_req, stall_M);
    end
    n_checks++;
    if (dm_addr !== 64'h40 || dm_we !== 1'b0) begin
      n_fail++; $display("FAIL load_addr: addr=%0h we=%b want 40/0", dm_addr, dm_we);
    end
    tick();
    n_checks++;
    if (readData_W !== 64'hDEAD || valid_W !== 1'b1) begin
      n_fail++; $display("FAIL load_wb: rd=%0h valid=%b want dead/1", readData_W, valid_W);
    end
    n_checks++;
    if (aluResult_W !== 64'h40 || writeReg_W !== 5'd5 || RegWrite_W !== 1'b1 || MemtoReg_W !== 1'b1) begin
      n_fail++; $display("FAIL load_wb_ctrl: alu=%0h wr=%0d rw=%b m2r=%b want 40/5/1/1", aluResult_W, writeReg_W, RegWrite_W, MemtoReg_W);
    end
    n_checks++;
    if (dm_req !== 1'b0) begin
      n_fail++; $display("FAIL load_idle: dm_req=%b want 0", dm_req);
    end
    dm_ready = 0; dm_rdata = '0;
  endtask

  task automatic test_store_wait();
    int stalls = 0;
    int bad = 0;
    valid_E = 1; MemWrite_E = 1; aluResult_E = 64'h80; writeData_E = 64'h1234;
    dm_ready = 0;
    tick();
    clear_e();
    for (int i = 1; i <= 4; i++) begin
      dm_ready = (i == 4);
      #1;
      if (stall_M) stalls++;
      if (dm_req !== 1'b1 || dm_we !== 1'b1 || dm_addr !== 64'h80 || dm_wdata !== 64'h1234 || valid_W !== 1'b0)
        bad++;
      if (i < 4 && stall_M !== 1'b1) bad++;
      tick();
    end
    dm_ready = 0;
    n_checks++;
    if (stalls !== 3) begin
      n_fail++; $display("FAIL store_stall_count: got %0d want 3", stalls);
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL store_stable: %0d bad cycles want 0", bad);
    end
    n_checks++;
    if (valid_W !== 1'b1 || RegWrite_W !== 1'b0 || aluResult_W !== 64'h80 || readData_W !== '0) begin
      n_fail++; $display("FAIL store_wb: valid=%b rw=%b alu=%0h rd=%0h want 1/0/80/0", valid_W, RegWrite_W, aluResult_W, readData_W);
    end
    n_checks++;
    if (dm_req !== 1'b0 || stall_M !== 1'b0) begin
      n_fail++; $display("FAIL store_done: req=%b stall=%b want 0/0", dm_req, stall_M);
    end
  endtask

  task automatic test_branch();
    valid_E = 1; Branch_E = 1; zero_E = 1; PCBranch_E = 64'h100;
    tick();
    clear_e();
    #1;
    n_checks++;
    if (PCSrc_M !== 1'b1 || PCBranch_M !== 64'h100) begin
      n_fail++; $display("FAIL branch_taken: pcsrc=%b pcb=%0h want 1/100", PCSrc_M, PCBranch_M);
    end
    valid_E = 1; Branch_E = 1; zero_E = 0; PCBranch_E = 64'h100;
    tick();
    clear_e();
    #1;
    n_checks++;
    if (PCSrc_M !== 1'b0 || PCBranch_M !== 64'h100) begin
      n_fail++; $display("FAIL branch_not_taken: pcsrc=%b pcb=%0h want 0/100", PCSrc_M, PCBranch_M);
    end
    tick();
  endtask

  task automatic test_misaligned();
    int bad = 0;
    valid_E = 1; MemRead_E = 1; aluResult_E = 64'h44;
    dm_ready = 1;
    tick();
    clear_e();
    #1;
    n_checks++;
    if (dm_req !== 1'b0) begin
      n_fail++; $display("FAIL misalign_req: dm_req=%b want 0", dm_req);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (dm_req !== 1'b0 || stall_M !== 1'b1 || fault !== 1'b1 || fault_code !== 2'b01 || valid_W !== 1'b0)
        bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL misalign_fault: %0d bad cycles, last fault=%b code=%b stall=%b want 1/01/1", bad, fault, fault_code, stall_M);
    end
    dm_ready = 0;
    do_reset();
    n_checks++;
    if (fault !== 1'b0 || fault_code !== 2'b00 || stall_M !== 1'b0) begin
      n_fail++; $display("FAIL misalign_reset: fault=%b code=%b stall=%b want 0/00/0", fault, fault_code, stall_M);
    end
  endtask

  task automatic test_timeout();
    int bad = 0;
    valid_E = 1; MemRead_E = 1; aluResult_E = 64'h40;
    dm_ready = 0;
    tick();
    clear_e();
    // request cycle in IDLE followed by 4 WAIT cycles
    for (int i = 0; i < 5; i++) begin
      if (dm_req !== 1'b1 || stall_M !== 1'b1 || fault !== 1'b0) bad++;
      tick();
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL timeout_wait: %0d bad cycles want 0", bad);
    end
    n_checks++;
    if (fault !== 1'b1 || fault_code !== 2'b10 || dm_req !== 1'b0 || stall_M !== 1'b1) begin
      n_fail++; $display("FAIL timeout_fault: fault=%b code=%b req=%b stall=%b want 1/10/0/1", fault, fault_code, dm_req, stall_M);
    end
    do_reset();
    n_checks++;
    if (fault !== 1'b0 || fault_code !== 2'b00) begin
      n_fail++; $display("FAIL timeout_reset: fault=%b code=%b want 0/00", fault, fault_code);
    end
    valid_E = 1; MemRead_E = 1; RegWrite_E = 1; aluResult_E = 64'h48; writeReg_E = 5'd9;
    dm_ready = 1; dm_rdata = 64'hBEEF;
    tick();
    clear_e();
    tick();
    n_checks++;
    if (readData_W !== 64'hBEEF || valid_W !== 1'b1 || writeReg_W !== 5'd9) begin
      n_fail++; $display("FAIL timeout_recover: rd=%0h valid=%b wr=%0d want beef/1/9", readData_W, valid_W, writeReg_W);
    end
    dm_ready = 0; dm_rdata = '0;
  endtask

  task automatic test_reset_mid_wait();
    valid_E = 1; MemRead_E = 1; RegWrite_E = 1; aluResult_E = 64'h88; writeReg_E = 5'd3;
    Branch_E = 1; zero_E = 1; PCBranch_E = 64'h200;
    dm_ready = 0;
    tick();
    clear_e();
    tick();
    n_checks++;
    if (dm_req !== 1'b1 || stall_M !== 1'b1) begin
      n_fail++; $display("FAIL midwait_pre: req=%b stall=%b want 1/1", dm_req, stall_M);
    end
    tick();
    reset = 1; dm_ready = 1; dm_rdata = 64'hCAFE;
    tick();
    reset = 0; dm_ready = 0; dm_rdata = '0;
    #1;
    n_checks++;
    if (dm_req !== 1'b0 || stall_M !== 1'b0 || PCSrc_M !== 1'b0) begin
      n_fail++; $display("FAIL midwait_ctrl: req=%b stall=%b pcsrc=%b want 0/0/0", dm_req, stall_M, PCSrc_M);
    end
    n_checks++;
    if ({valid_W, RegWrite_W, MemtoReg_W, writeReg_W, aluResult_W, readData_W} !== '0) begin
      n_fail++; $display("FAIL midwait_wb: valid=%b rw=%b wr=%0d alu=%0h rd=%0h want 0", valid_W, RegWrite_W, writeReg_W, aluResult_W, readData_W);
    end
    valid_E = 1; MemRead_E = 1; aluResult_E = 64'h10;
    dm_ready = 1; dm_rdata = 64'h77;
    tick();
    clear_e();
    #1;
    n_checks++;
    if (dm_req !== 1'b1 || stall_M !== 1'b0) begin
      n_fail++; $display("FAIL midwait_idle: req=%b stall=%b want 1/0", dm_req, stall_M);
    end
    tick();
    n_checks++;
    if (readData_W !== 64'h77 || valid_W !== 1'b1) begin
      n_fail++; $display("FAIL midwait_next_load: rd=%0h valid=%b want 77/1", readData_W, valid_W);
    end
    dm_ready = 0; dm_rdata = '0;
  endtask

  initial begin
    reset = 1;
    test_reset();
    test_load_zero_wait();
    test_store_wait();
    test_branch();
    test_misaligned();
    test_timeout();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
